// File: rtl/comparator_pkg.sv
// Shared result encoding for the registered magnitude comparator.
// Results are carried as a packed {lt, eq, gt} triple.
package comparator_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_LT   = 3'b100;
  localparam cmp_res_t CMP_EQ   = 3'b010;
  localparam cmp_res_t CMP_GT   = 3'b001;
  localparam cmp_res_t CMP_NONE = 3'b000;

endpackage

// File: rtl/comparator_sync_if.sv
// Operand/result bundle between a producer, the comparator and its consumer.
interface comparator_sync_if #(
  parameter int unsigned WIDTH = 2
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_less_b;
  logic             a_equal_b;
  logic             a_greater_b;
  logic             out_valid;

  modport master (
    output in_valid, a, b,
    input  a_less_b, a_equal_b, a_greater_b, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output a_less_b, a_equal_b, a_greater_b, out_valid
  );

endinterface

// File: rtl/comparator_sync_cmp_cell.sv
// One-bit compare cell: passes a decided relation through, otherwise
// resolves it from this bit pair.
module cmp_cell
  import comparator_pkg::*;
(
  input  logic     a_bit,
  input  logic     b_bit,
  input  cmp_res_t cas_in,
  output cmp_res_t cas_out
);

  always_comb begin
    cas_out = cas_in;
    if (cas_in.eq) begin
      cas_out.lt = ~a_bit & b_bit;
      cas_out.eq = ~(a_bit ^ b_bit);
      cas_out.gt = a_bit & ~b_bit;
    end
  end

endmodule

// File: rtl/comparator_sync.sv
// Registered one-hot magnitude comparator, unsigned or two's-complement,
// one cycle of latency and one result per cycle.
module comparator_sync
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter bit          SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  comparator_sync_if.slave  bus
);

  logic [WIDTH-1:0] a_cond;
  logic [WIDTH-1:0] b_cond;
  cmp_res_t         chain [WIDTH+1];
  cmp_res_t         res_q;
  logic             valid_q;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    a_cond = bus.a;
    b_cond = bus.b;
    if (SIGNED) begin
      a_cond[WIDTH-1] = ~bus.a[WIDTH-1];
      b_cond[WIDTH-1] = ~bus.b[WIDTH-1];
    end
  end

  assign chain[WIDTH] = CMP_EQ;

  // MSB-first cascade: the first differing bit decides the relation.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    cmp_cell u_cell (
      .a_bit   (a_cond[i]),
      .b_bit   (b_cond[i]),
      .cas_in  (chain[i+1]),
      .cas_out (chain[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= CMP_NONE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q <= chain[0];
      end
    end
  end

  assign bus.a_less_b    = res_q.lt;
  assign bus.a_equal_b   = res_q.eq;
  assign bus.a_greater_b = res_q.gt;
  assign bus.out_valid   = valid_q;

endmodule

// File: tb/tb_comparator_sync.sv
// Directed and exhaustive bench for comparator_sync, driving an unsigned and
// a signed instance with identical stimulus.
module tb_comparator_sync;

  localparam int unsigned W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  comparator_sync_if #(.WIDTH(W)) bus_u ();
  comparator_sync_if #(.WIDTH(W)) bus_s ();

  comparator_sync #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u.slave)
  );

  comparator_sync #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] q_u [$];
  logic [2:0] q_s [$];
  logic [2:0] exp_u = 3'b000;
  logic [2:0] exp_s = 3'b000;

  // Reference relation from integer values, {lt, eq, gt}.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit sgn);
    int va;
    int vb;
    va = int'(a);
    vb = int'(b);
    if (sgn && a[W-1]) va = va - (1 << W);
    if (sgn && b[W-1]) vb = vb - (1 << W);
    if (va < vb) return 3'b100;
    if (va > vb) return 3'b001;
    return 3'b010;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock of stimulus to both instances, then score both outputs.
  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    logic       ov;
    logic [3:0] obs_u;
    logic [3:0] obs_s;
    rst_n          = rst;
    bus_u.in_valid = v;
    bus_u.a        = a;
    bus_u.b        = b;
    bus_s.in_valid = v;
    bus_s.a        = a;
    bus_s.b        = b;
    if (!rst) begin
      q_u.delete();
      q_s.delete();
    end else if (v) begin
      q_u.push_back(ref_cmp(a, b, 1'b0));
      q_s.push_back(ref_cmp(a, b, 1'b1));
    end
    @(posedge clk);
    #1;
    ov = rst && v;
    if (!rst) begin
      exp_u = 3'b000;
      exp_s = 3'b000;
    end else if (bus_u.out_valid || bus_s.out_valid || ov) begin
      if (q_u.size() > 0) exp_u = q_u.pop_front();
      if (q_s.size() > 0) exp_s = q_s.pop_front();
    end
    obs_u = {bus_u.out_valid, bus_u.a_less_b, bus_u.a_equal_b, bus_u.a_greater_b};
    obs_s = {bus_s.out_valid, bus_s.a_less_b, bus_s.a_equal_b, bus_s.a_greater_b};
    chk({tag, "_unsigned"}, obs_u, {ov, exp_u});
    chk({tag, "_signed"}, obs_s, {ov, exp_s});
    if (obs_u[3]) chk({tag, "_unsigned_onehot"}, 4'($countones(obs_u[2:0])), 4'd1);
    if (obs_s[3]) chk({tag, "_signed_onehot"}, 4'($countones(obs_s[2:0])), 4'd1);
  endtask

  initial begin
    bus_u.in_valid = 1'b0;
    bus_u.a        = '0;
    bus_u.b        = '0;
    bus_s.in_valid = 1'b0;
    bus_s.a        = '0;
    bus_s.b        = '0;

    // Reset with a valid input pending: reset wins.
    step("reset0", 1'b0, 1'b1, 2'd3, 2'd0);
    step("reset1", 1'b0, 1'b1, 2'd3, 2'd0);

    // Directed back-to-back sweep, first valid right after reset release.
    step("sweep00", 1'b1, 1'b1, 2'd0, 2'd0);
    step("sweep12", 1'b1, 1'b1, 2'd1, 2'd2);
    step("sweep21", 1'b1, 1'b1, 2'd2, 2'd1);
    step("sweep33", 1'b1, 1'b1, 2'd3, 2'd3);

    // Flags hold while idle, operands changing underneath.
    step("hold_load", 1'b1, 1'b1, 2'd1, 2'd2);
    step("hold1", 1'b1, 1'b0, 2'd3, 2'd0);
    step("hold2", 1'b1, 1'b0, 2'd0, 2'd3);
    step("hold3", 1'b1, 1'b0, 2'd2, 2'd2);

    // Sign-sensitive pairs.
    step("sgn_10_01", 1'b1, 1'b1, 2'b10, 2'b01);
    step("sgn_11_10", 1'b1, 1'b1, 2'b11, 2'b10);
    step("sgn_00_11", 1'b1, 1'b1, 2'b00, 2'b11);

    // Reset for one edge in the middle of a valid stream.
    step("mid_pre", 1'b1, 1'b1, 2'd2, 2'd3);
    step("mid_rst", 1'b0, 1'b1, 2'd3, 2'd2);
    step("mid_post", 1'b1, 1'b1, 2'd3, 2'd2);
    step("mid_idle", 1'b1, 1'b0, 2'd0, 2'd0);

    // All operand pairs, back to back.
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        step($sformatf("exh_%0d_%0d", ia, ib), 1'b1, 1'b1, W'(ia), W'(ib));
      end
    end
    step("final_idle", 1'b1, 1'b0, 2'd1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_sync.md
# comparator_sync

Registered magnitude comparator with a parameterized operand width. It compares two operands `a` and `b` and reports exactly one of less-than, equal or greater-than, one clock after a valid input. It sits as a leaf datapath block: producers drive operands with a valid strobe, and consumers sample the registered one-hot result.

## Interface
Parameters:
- `WIDTH`, default 2: operand width in bits; any value of 1 or more is legal.
- `SIGNED`, default 0: 0 compares unsigned; 1 compares two's-complement.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `in_valid`  input  1: when high, `a` and `b` are captured on this edge.
- `a`  input  WIDTH: operand A.
- `b`  input  WIDTH: operand B.
- `a_less_b`  output  1: registered A < B.
- `a_equal_b`  output  1: registered A == B.
- `a_greater_b`  output  1: registered A > B.
- `out_valid`  output  1: high for one cycle when the three flags hold a fresh result.

## Operation
- On a rising edge with `rst_n`=1 and `in_valid`=1, compute the relation of `a` to `b` and register it.
  - Exactly one of the three flags is 1.
  - `out_valid` is registered to 1.
- On a rising edge with `rst_n`=1 and `in_valid`=0:
  - the three flags hold their previous values;
  - `out_valid` is registered to 0.
- Unsigned mode (`SIGNED`=0): operands are plain binary, ranging from 0 to 2^WIDTH−1.
- Signed mode (`SIGNED`=1): the MSB is the sign bit.
  - For WIDTH=2, 2'b10 (−2) < 2'b11 (−1) < 2'b00 (0) < 2'b01 (1).
  - Implement by inverting both MSBs and then doing an unsigned compare.
- Equality is bitwise and independent of `SIGNED`.
- Compare MSB-first: the first differing bit position decides less or greater. If no bit differs, the result is equal.
- Operands containing X or Z are out of scope. No output requirement applies to them.

## Timing
- Latency: exactly 1 cycle, from the `in_valid` edge to the flags and `out_valid`.
- Throughput: one comparison per cycle; back-to-back `in_valid` is allowed.
- There is no backpressure and no ready signal.
- Reset values, taken at a rising edge with `rst_n`=0:
  - `a_less_b`=0, `a_equal_b`=0, `a_greater_b`=0, `out_valid`=0.
  - The all-zero flag state is legal only after reset and before the first valid input.
- Reset asserted in the same cycle as `in_valid`: reset wins, the input is discarded and all outputs are 0.
- Reset deasserted: the first edge with `rst_n`=1 and `in_valid`=1 produces a result on that edge. No extra recovery cycle is inserted.
- Outputs change only on clock edges. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `comparator_pkg` holds:
  - the result encoding constants `CMP_LT`=3'b100, `CMP_EQ`=3'b010, `CMP_GT`=3'b001, ordered {less, equal, greater};
  - the reset result constant `CMP_NONE`=3'b000.
- Sub-module `cmp_cell`: a 1-bit combinational compare cell.
  - Inputs: `a_bit`, `b_bit`, and the upstream {lt, eq, gt} cascade from the more significant bits.
  - Output: the cascaded {lt, eq, gt}.
  - Generate one cell per bit, chained from the MSB, with the cascade seeded at {0, 1, 0}.
- The top level contains:
  - MSB sign conditioning;
  - the generate chain;
  - the result and `out_valid` registers with synchronous reset.

## Test plan
All cases use WIDTH=2 and SIGNED=0 unless a case says otherwise.
- Reset: hold `rst_n`=0 for 2 edges with `in_valid`=1, a=3, b=0 → all four outputs 0.
- Directed sweep: apply valid (a,b) = (0,0), (1,2), (2,1), (3,3) on consecutive edges → one cycle later, flags {lt, eq, gt} = 010, 100, 001, 010, with `out_valid`=1 on each of those cycles.
- Hold: apply valid a=1, b=2, then hold `in_valid`=0 for 3 cycles while changing a and b → flags stay 100 and `out_valid`=0 after the first result.
- Signed: with SIGNED=1, apply a=2'b10, b=2'b01 → 100. Then apply a=2'b11, b=2'b10 → 001.
- Mid-stream reset: assert `rst_n`=0 for one edge during back-to-back valids → all outputs 0 on that cycle, and the next valid input produces its result one cycle later.
- Exhaustive: all 16 pairs in both modes, against a software model → exactly one flag high per result.
